// File: rtl/ip_pkg.sv
// ---------------------------------------------------------------------------
// ip_pkg
// Shared IPv4 definitions for the TX header builder and the RX header parser:
// FSM state type, fixed header constants, protocol numbers, the latched
// header-field record and helpers that map the record onto 16-bit header
// words and onto serial header bytes (network order, MSB first).
// ---------------------------------------------------------------------------
package ip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FOLD = 2'd2,
    ST_SEND = 2'd3
  } ip_state_t;

  localparam logic [3:0] IPV4_VERSION   = 4'd4;
  localparam logic [3:0] IPV4_IHL_MIN   = 4'd5;
  localparam logic [4:0] IPV4_HDR_BYTES = 5'd20;
  localparam logic [3:0] IPV4_HDR_WORDS = 4'd10;

  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_TCP  = 8'd6;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  // Index of the final header byte / final header word.
  localparam logic [4:0] LAST_BYTE_IDX = IPV4_HDR_BYTES - 5'd1;
  localparam logic [3:0] LAST_WORD_IDX = IPV4_HDR_WORDS - 4'd1;

  typedef struct packed {
    logic [7:0]  tos;
    logic [15:0] total_length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } ip_hdr_fields_t;

  // 16-bit header word 0..9; word 5 carries the supplied checksum value
  // (pass zero while the checksum itself is being computed).
  function automatic logic [15:0] hdr_word(input ip_hdr_fields_t f,
                                           input logic [15:0]    csum,
                                           input logic [3:0]     idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {IPV4_VERSION, IPV4_IHL_MIN, f.tos};
      4'd1:    w = f.total_length;
      4'd2:    w = f.identification;
      4'd3:    w = {f.flags, f.fragment_offset};
      4'd4:    w = {f.ttl, f.protocol};
      4'd5:    w = csum;
      4'd6:    w = f.source_ip[31:16];
      4'd7:    w = f.source_ip[15:0];
      4'd8:    w = f.dest_ip[31:16];
      4'd9:    w = f.dest_ip[15:0];
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Header byte 0..19: even bytes are the high half of a word.
  function automatic logic [7:0] hdr_byte(input ip_hdr_fields_t f,
                                          input logic [15:0]    csum,
                                          input logic [4:0]     idx);
    logic [15:0] w;
    w = hdr_word(f, csum, idx[4:1]);
    return idx[0] ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/ip_csum_accum.sv
// ---------------------------------------------------------------------------
// ip_csum_accum
// 20-bit ones'-complement checksum accumulator. Words are summed with the
// carries kept in the upper nibble; the fold/invert output turns the running
// sum into an IPv4 header checksum. On the RX side a correct header folds to
// zero, so the same block serves for checking.
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset (accumulator := 0)
//   clear_i   zero the accumulator (has priority over add_i)
//   add_i     add word_i into the accumulator this cycle
//   word_i    16-bit word to add
//   csum_o    ~fold(accumulator), combinational from the register
// ---------------------------------------------------------------------------
module ip_csum_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q;
  logic [19:0] acc_d;
  logic [16:0] s1;
  logic [15:0] s2;

  // Next accumulator value: clear, add or hold.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = 20'd0;
    end else if (add_i) begin
      acc_d = acc_q + {4'd0, word_i};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 20'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Two folds are enough: ten words cannot push s1 past 0x1000E, so the
  // second add never carries again.
  always_comb begin
    s1     = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    s2     = s1[15:0] + {15'd0, s1[16]};
    csum_o = ~s2;
  end

endmodule

// File: rtl/ip_header_builder.sv
// ---------------------------------------------------------------------------
// ip_header_builder
// TX IPv4 header generator. On start (in IDLE) all header fields are latched,
// the header checksum is accumulated over ten words and folded (or taken from
// header_checksum_in when CALC_CHECKSUM=0), then the 20-byte option-less
// header is sent MSB-first on a valid/ready byte stream.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   start                  build one header (sampled only in IDLE)
//   tos .. dest_ip         header fields, latched on the accepted start
//   header_checksum_in     checksum sent verbatim when CALC_CHECKSUM=0
//   data_out/valid/ready   byte stream; data_last marks byte 19
//   busy                   high in every state but IDLE
//   done                   one-cycle pulse after byte 19 is accepted
//   checksum_out           checksum placed in bytes 10-11
// All outputs are registered; data_valid never depends on data_ready within
// the same cycle.
// ---------------------------------------------------------------------------
module ip_header_builder #(
  parameter bit CALC_CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  tos,
  input  logic [15:0] total_length,
  input  logic [15:0] identification,
  input  logic [2:0]  flags,
  input  logic [12:0] fragment_offset,
  input  logic [7:0]  ttl,
  input  logic [7:0]  protocol,
  input  logic [15:0] header_checksum_in,
  input  logic [31:0] source_ip,
  input  logic [31:0] dest_ip,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        data_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum_out
);

  import ip_pkg::*;

  ip_state_t      state_q,      state_d;
  logic [4:0]     idx_q,        idx_d;      // word index in CALC, byte index in SEND
  ip_hdr_fields_t fields_q,     fields_d;
  logic [7:0]     data_out_q,   data_out_d;
  logic           data_valid_q, data_valid_d;
  logic           data_last_q,  data_last_d;
  logic           busy_q,       busy_d;
  logic           done_q,       done_d;
  logic [15:0]    csum_q,       csum_d;

  ip_hdr_fields_t fields_in;
  logic           acc_clear;
  logic           acc_add;
  logic [15:0]    acc_word;
  logic [15:0]    acc_csum;
  logic [4:0]     idx_next;

  // Gather the field inputs into one record.
  always_comb begin
    fields_in.tos             = tos;
    fields_in.total_length    = total_length;
    fields_in.identification  = identification;
    fields_in.flags           = flags;
    fields_in.fragment_offset = fragment_offset;
    fields_in.ttl             = ttl;
    fields_in.protocol        = protocol;
    fields_in.source_ip       = source_ip;
    fields_in.dest_ip         = dest_ip;
  end

  ip_csum_accum u_csum (
    .clk     (clk),
    .rst     (rst),
    .clear_i (acc_clear),
    .add_i   (acc_add),
    .word_i  (acc_word),
    .csum_o  (acc_csum)
  );

  assign idx_next = idx_q + 5'd1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fields_d     = fields_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    data_last_d  = data_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    csum_d       = csum_q;
    acc_clear    = 1'b0;
    acc_add      = 1'b0;
    // Checksum field counts as zero while summing.
    acc_word     = hdr_word(fields_q, 16'h0000, idx_q[3:0]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fields_d  = fields_in;
          idx_d     = 5'd0;
          busy_d    = 1'b1;
          acc_clear = 1'b1;
          if (CALC_CHECKSUM) begin
            state_d = ST_CALC;
          end else begin
            // No computation: the first byte is presented right away.
            state_d      = ST_SEND;
            csum_d       = header_checksum_in;
            data_valid_d = 1'b1;
            data_out_d   = hdr_byte(fields_in, header_checksum_in, 5'd0);
            data_last_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        acc_add = 1'b1;
        if (idx_q[3:0] == LAST_WORD_IDX) begin
          state_d = ST_FOLD;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_next;
        end
      end

      ST_FOLD: begin
        // The accumulator now holds all ten words; the folded value goes
        // straight into the register and into byte 0 presentation.
        state_d      = ST_SEND;
        csum_d       = acc_csum;
        idx_d        = 5'd0;
        data_valid_d = 1'b1;
        data_out_d   = hdr_byte(fields_q, acc_csum, 5'd0);
        data_last_d  = 1'b0;
      end

      ST_SEND: begin
        if (data_valid_q && data_ready) begin
          if (idx_q == LAST_BYTE_IDX) begin
            state_d      = ST_IDLE;
            idx_d        = 5'd0;
            data_valid_d = 1'b0;
            data_last_d  = 1'b0;
            data_out_d   = 8'h00;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            idx_d       = idx_next;
            data_out_d  = hdr_byte(fields_q, csum_q, idx_next);
            data_last_d = (idx_next == LAST_BYTE_IDX);
          end
        end else begin
          // Stalled: everything holds.
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        idx_d        = 5'd0;
        data_valid_d = 1'b0;
        data_last_d  = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 5'd0;
      fields_q     <= '0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      csum_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fields_q     <= fields_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      csum_q       <= csum_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign data_last    = data_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum_out = csum_q;

endmodule

// File: tb/tb_ip_header_builder.sv
module tb_ip_header_builder;
  import ip_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           start1 = 1'b0;
  logic           start0 = 1'b0;
  logic           data_ready = 1'b1;
  ip_hdr_fields_t fin = '0;
  logic [15:0]    csum_in = 16'h0000;

  logic [7:0]  d1_data, d0_data;
  logic        d1_valid, d0_valid, d1_last, d0_last;
  logic        d1_busy, d0_busy, d1_done, d0_done;
  logic [15:0] d1_csum, d0_csum;

  ip_header_builder #(.CALC_CHECKSUM(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .tos(fin.tos), .total_length(fin.total_length), .identification(fin.identification),
    .flags(fin.flags), .fragment_offset(fin.fragment_offset), .ttl(fin.ttl),
    .protocol(fin.protocol), .header_checksum_in(csum_in),
    .source_ip(fin.source_ip), .dest_ip(fin.dest_ip),
    .data_out(d1_data), .data_valid(d1_valid), .data_ready(data_ready),
    .data_last(d1_last), .busy(d1_busy), .done(d1_done), .checksum_out(d1_csum));

  ip_header_builder #(.CALC_CHECKSUM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .tos(fin.tos), .total_length(fin.total_length), .identification(fin.identification),
    .flags(fin.flags), .fragment_offset(fin.fragment_offset), .ttl(fin.ttl),
    .protocol(fin.protocol), .header_checksum_in(csum_in),
    .source_ip(fin.source_ip), .dest_ip(fin.dest_ip),
    .data_out(d0_data), .data_valid(d0_valid), .data_ready(data_ready),
    .data_last(d0_last), .busy(d0_busy), .done(d0_done), .checksum_out(d0_csum));

  // Which DUT the monitor watches: 0 = computed checksum, 1 = passthrough.
  bit sel = 1'b0;
  wire [7:0]  mon_data  = sel ? d0_data  : d1_data;
  wire        mon_valid = sel ? d0_valid : d1_valid;
  wire        mon_last  = sel ? d0_last  : d1_last;
  wire        mon_busy  = sel ? d0_busy  : d1_busy;
  wire        mon_done  = sel ? d0_done  : d1_done;
  wire [15:0] mon_csum  = sel ? d0_csum  : d1_csum;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [159:0] model_hdr(input ip_hdr_fields_t f, input logic [15:0] cs);
    return {8'h45, f.tos, f.total_length, f.identification, f.flags, f.fragment_offset,
            f.ttl, f.protocol, cs, f.source_ip, f.dest_ip};
  endfunction

  function automatic logic [15:0] model_csum(input ip_hdr_fields_t f);
    logic [159:0] h;
    int unsigned  sum;
    logic [15:0]  r;
    h   = model_hdr(f, 16'h0000);
    sum = 0;
    for (int i = 0; i < 10; i++) sum += h[159-16*i -: 16];
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    r = sum[15:0];
    return ~r;
  endfunction

  logic [7:0]  exp_q[$];
  logic [15:0] exp_csum = 16'h0000;
  bit          mon_en = 1'b1;
  int          hs_cnt = 0, done_cnt = 0, stall_cnt = 0;
  int          hs_base = 0, done_base = 0, stall_base = 0;

  task automatic load_expected(input ip_hdr_fields_t f, input logic [15:0] cs);
    logic [159:0] h;
    h = model_hdr(f, cs);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(h[159-8*i -: 8]);
  endtask

  // Compare process: every cycle a byte is presented it must be the next
  // expected one; done may only follow the final handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mon_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, mon_valid}, 32'd0);
        end else begin
          chk("data_out", {24'd0, mon_data}, {24'd0, exp_q[0]});
          chk("data_last", {31'd0, mon_last}, {31'd0, exp_q.size() == 1});
          chk("checksum_out", {16'd0, mon_csum}, {16'd0, exp_csum});
          if (data_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end else begin
            stall_cnt++;
          end
        end
      end
      if (exp_q.size() > 0) chk("busy", {31'd0, mon_busy}, 32'd1);
      if (mon_done) begin
        done_cnt++;
        chk("done_after_last", exp_q.size(), 32'd0);
        chk("busy_in_done", {31'd0, mon_busy}, 32'd0);
      end
    end
  end

  // data_ready driver: 0 = always ready, 1 = random, 2 = 3-cycle stall on byte 10.
  int ready_mode = 0;
  int stall_left = 0;
  bit stall_used = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: data_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          data_ready = 1'b0;
          stall_left--;
        end else if (!stall_used && mon_valid && hs_cnt == hs_base + 10) begin
          data_ready = 1'b0;
          stall_left = 2;
          stall_used = 1'b1;
        end else begin
          data_ready = 1'b1;
        end
      end
      default: data_ready = 1'b1;
    endcase
  end

  // Pulse start on the chosen DUT; returns just after the accepting edge.
  task automatic send_start(input ip_hdr_fields_t f, input bit use0);
    @(posedge clk); #2;
    fin = f;
    if (use0) start0 = 1'b1; else start1 = 1'b1;
    hs_base = hs_cnt; done_base = done_cnt; stall_base = stall_cnt;
    @(posedge clk); #2;
    start0 = 1'b0; start1 = 1'b0;
    exp_csum = use0 ? csum_in : model_csum(f);
    load_expected(f, exp_csum);
  endtask

  // Cycles from the accepting edge to the first visible data_valid.
  task automatic measure_latency(output int cyc);
    cyc = 1;
    while (!mon_valid && cyc < 40) begin
      @(posedge clk); #2;
      cyc++;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && done_cnt > done_base) && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_done_count"}, done_cnt - done_base, 32'd1);
    chk({name, "_handshakes"}, hs_cnt - hs_base, 32'd20);
  endtask

  ip_hdr_fields_t basic, ones, f, other;
  int             lat;
  logic [159:0]   h;
  logic [7:0]     lit [20];
  logic [31:0]    r1, r2, r3;
  logic [7:0]     protos [3];

  initial begin
    basic = '{tos: 8'h00, total_length: 16'h0073, identification: 16'h0000, flags: 3'd2,
              fragment_offset: 13'd0, ttl: 8'h40, protocol: 8'h11,
              source_ip: 32'hC0A80001, dest_ip: 32'hC0A800C7};
    ones  = '{tos: 8'hFF, total_length: 16'hFFFF, identification: 16'hFFFF, flags: 3'd7,
              fragment_offset: 13'h1FFF, ttl: 8'hFF, protocol: 8'hFF,
              source_ip: 32'hFFFFFFFF, dest_ip: 32'hFFFFFFFF};
    lit = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    protos = '{PROTO_ICMP, PROTO_TCP, PROTO_UDP};

    // Model pinned against hand-computed values.
    chk("model_basic_csum", {16'd0, model_csum(basic)}, 32'h0000B861);
    chk("model_ones_csum", {16'd0, model_csum(ones)}, 32'h0000BA00);
    h = model_hdr(basic, model_csum(basic));
    for (int i = 0; i < 20; i++) chk("model_basic_byte", {24'd0, h[159-8*i -: 8]}, {24'd0, lit[i]});

    // Reset state.
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, d1_valid}, 32'd0);
    chk("rst_busy", {31'd0, d1_busy}, 32'd0);
    chk("rst_done", {31'd0, d1_done}, 32'd0);
    chk("rst_last", {31'd0, d1_last}, 32'd0);
    chk("rst_data", {24'd0, d1_data}, 32'd0);
    chk("rst_csum", {16'd0, d1_csum}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic header.
    send_start(basic, 1'b0);
    measure_latency(lat);
    chk("basic_latency", lat, 32'd12);
    wait_done("basic");
    chk("basic_csum_hold", {16'd0, d1_csum}, 32'h0000B861);

    // Carry fold.
    send_start(ones, 1'b0);
    wait_done("ones");
    chk("ones_csum", {16'd0, d1_csum}, 32'h0000BA00);

    // Backpressure on byte 10.
    ready_mode = 2; stall_used = 1'b0;
    send_start(basic, 1'b0);
    wait_done("bp");
    chk("bp_stall_cycles", stall_cnt - stall_base, 32'd3);
    ready_mode = 0;

    // Start while busy, field change after start.
    send_start(basic, 1'b0);
    fin.source_ip = 32'h0A000001;
    other = ones;
    repeat (3) @(posedge clk);
    #2; fin = other; start1 = 1'b1;
    @(posedge clk); #2; start1 = 1'b0;
    while (!mon_valid) begin @(posedge clk); #2; end
    repeat (4) @(posedge clk);
    #2; start1 = 1'b1;
    @(posedge clk); #2; start1 = 1'b0;
    wait_done("busy_start");
    chk("busy_start_csum", {16'd0, d1_csum}, 32'h0000B861);

    // Reset while byte 7 is presented.
    send_start(basic, 1'b0);
    lat = 0;
    while (hs_cnt != hs_base + 7 && lat < 100) begin @(posedge clk); #2; lat++; end
    chk("rst_mid_reached", hs_cnt - hs_base, 32'd7);
    mon_en = 1'b0; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    chk("rst_mid_valid", {31'd0, d1_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, d1_busy}, 32'd0);
    chk("rst_mid_csum", {16'd0, d1_csum}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", {31'd0, d1_done}, 32'd0);
    end
    exp_q.delete();
    mon_en = 1'b1;
    send_start(basic, 1'b0);
    wait_done("after_rst");

    // Passthrough checksum.
    sel = 1'b1; csum_in = 16'h1234;
    send_start(basic, 1'b1);
    chk("pass_byte10_model", {24'd0, exp_q[10]}, 32'h12);
    measure_latency(lat);
    chk("pass_latency", lat, 32'd1);
    wait_done("pass");
    chk("pass_csum", {16'd0, d0_csum}, 32'h00001234);
    sel = 1'b0;

    // Randomized headers with random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      f.tos = r1[7:0]; f.total_length = r1[31:16]; f.identification = r2[15:0];
      f.flags = r2[18:16]; f.fragment_offset = r3[12:0]; f.ttl = r3[23:16];
      f.protocol = protos[$urandom_range(0, 2)];
      f.source_ip = $urandom; f.dest_ip = $urandom;
      send_start(f, 1'b0);
      wait_done("random");
    end
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ip_header_builder.md
Name: ip_header_builder

Overview:
Transmit-side IPv4 header generator. It latches header fields on a start pulse, computes the IPv4 header checksum, and serializes the 20-byte option-less header MSB-first onto an 8-bit valid/ready byte stream. It sits in front of the payload mux in the TX path and is the counterpart of the byte-serial IPv4 header parser on the RX path.

Parameters:
CALC_CHECKSUM, 1, 1 = compute the checksum internally; 0 = transmit header_checksum_in unchanged.

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request to build one header; sampled only in IDLE
tos  in  8  type of service
total_length  in  16  total length field
identification  in  16  identification field
flags  in  3  flags field
fragment_offset  in  13  fragment offset
ttl  in  8  time to live
protocol  in  8  protocol field
header_checksum_in  in  16  checksum used when CALC_CHECKSUM=0
source_ip  in  32  source address
dest_ip  in  32  destination address
data_out  out  8  header byte
data_valid  out  1  data_out is valid
data_ready  in  1  downstream accepts the byte
data_last  out  1  high with byte 19
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after byte 19 is accepted
checksum_out  out  16  checksum placed in bytes 10-11; stable from SEND until next start

Behaviour:
- Reset: sync, active-high. Returns to IDLE. data_out=0, data_valid=0, data_last=0, busy=0, done=0, checksum_out=0, accumulator=0, byte index=0. Reset mid-header aborts immediately with no done.
- Fixed fields: version=4, IHL=5. No options are supported.
- Byte order (network, MSB first): 0:0x45, 1:tos, 2-3:total_length, 4-5:identification, 6:{flags,fragment_offset[12:8]}, 7:fragment_offset[7:0], 8:ttl, 9:protocol, 10-11:checksum, 12-15:source_ip, 16-19:dest_ip.
- IDLE: when start=1, latch all field inputs and go to CALC (or to SEND if CALC_CHECKSUM=0). Field inputs are ignored after that edge.
- start while busy is ignored. It is not queued.
- CALC: runs 10 cycles. Each cycle adds one 16-bit header word (words 0-9, with word 5 = 0x0000) into a 20-bit accumulator. Accumulator is cleared on start.
- FOLD: 1 cycle.
  - s1 = acc[15:0] + acc[19:16] (17 bits).
  - s2 = s1[15:0] + s1[16].
  - checksum_out = ~s2.
  - Go to SEND.
- Latency: the first data_valid is high 12 cycles after the start-accepting edge (CALC_CHECKSUM=1), or 1 cycle after it (CALC_CHECKSUM=0).
- SEND handshake:
  - data_valid stays high and data_out/data_last stay stable until data_valid&data_ready.
  - The byte index advances only on a handshake.
  - data_ready may toggle freely and has no combinational path to data_valid.
- Last byte: on the handshake of byte 19, data_valid drops the next cycle, done=1 for exactly 1 cycle, and the state returns to IDLE (busy=0 in the same cycle as done).
- The earliest next start is accepted in the done cycle.
- States: IDLE, CALC, FOLD, SEND. Any illegal encoding goes to IDLE.

Decomposition:
- Package ip_pkg:
  - state enum;
  - IPV4_VERSION=4, IPV4_IHL_MIN=5, IPV4_HDR_BYTES=20, IPV4_HDR_WORDS=10;
  - protocol constants PROTO_ICMP=1, PROTO_TCP=6, PROTO_UDP=17.
- Sub-module ip_csum_accum: 20-bit ones'-complement accumulator with clear, add-word and fold/invert output. The RX parser will reuse it for checksum checking.

Test Plan:
- Basic header: tos=0x00, total_length=0x0073, identification=0x0000, flags=2, fragment_offset=0, ttl=0x40, protocol=0x11, source_ip=0xC0A80001, dest_ip=0xC0A800C7, data_ready=1.
  - Expected bytes: 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7.
  - checksum_out=0xB861; first valid 12 cycles after start; data_last only on C7; done pulses once.
- Carry fold: all fields all-ones, i.e. tos=0xFF, total_length=0xFFFF, identification=0xFFFF, flags=7, fragment_offset=0x1FFF, ttl=0xFF, protocol=0xFF, source_ip=dest_ip=0xFFFFFFFF.
  - Expected: checksum_out=0xBA00; bytes 10-11 = BA 00.
- Backpressure: basic header, with data_ready held low 3 cycles while byte 10 is presented.
  - Expected: data_out holds 0xB8 with data_valid=1 throughout; no byte is skipped or duplicated; total of 20 handshakes.
- Start while busy and field changes: pulse start again during CALC and SEND, and change source_ip after start.
  - Expected: the output stream is identical to the basic case; exactly one done.
- Reset mid-operation: assert rst at byte 7.
  - Expected: next cycle data_valid=0, busy=0, checksum_out=0, no done.
  - A following basic start then produces the full correct 20-byte header.
- CALC_CHECKSUM=0 with header_checksum_in=0x1234.
  - Expected: bytes 10-11 = 12 34; first data_valid 1 cycle after start.
